// File: rtl/axisp_arb_pkg.sv
// Shared types and helpers for the packet round-robin arbiter and future schedulers.
package axisp_arb_pkg;

  localparam int unsigned N_SRC_MAX = 16;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  // Winner is the first set bit strictly after rr_ptr, wrapping; rr_ptr itself is checked last.
  function automatic logic [3:0] rr_next(input logic [N_SRC_MAX-1:0] valid_vec,
                                         input logic [3:0]           rr_ptr,
                                         input int unsigned          n_src);
    logic [3:0]  win;
    int unsigned idx;
    win = rr_ptr;
    for (int unsigned k = 0; k < N_SRC_MAX; k++) begin
      if (k < n_src) begin
        idx = (32'(rr_ptr) + n_src - k) % n_src;
        if (valid_vec[idx[3:0]]) win = idx[3:0];
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/axisp_rr_pick.sv
// Combinational round-robin priority picker: valid vector + last-served pointer -> winner.
module axisp_rr_pick
  import axisp_arb_pkg::*;
#(
  parameter int unsigned N_SRC    = 4,
  parameter int unsigned IDX_BITS = 2
) (
  input  logic [N_SRC-1:0]    valid_i,
  input  logic [IDX_BITS-1:0] rr_ptr_i,
  output logic [IDX_BITS-1:0] winner_o,
  output logic                any_valid_o
);

  logic [N_SRC_MAX-1:0] vec;
  logic [3:0]           ptr;
  logic [3:0]           win;

  always_comb begin
    vec                 = '0;
    vec[N_SRC-1:0]      = valid_i;
    ptr                 = '0;
    ptr[IDX_BITS-1:0]   = rr_ptr_i;
    win                 = rr_next(vec, ptr, N_SRC);
    winner_o            = IDX_BITS'(win);
    any_valid_o         = |valid_i;
  end

endmodule

// File: rtl/axisp_arb_rr.sv
// Packet-granular round-robin AXI4-Stream arbiter with one arbitration bubble per packet.
// Optional per-source packet and stall counters under `AXISP_ARB_STATS_EN.
module axisp_arb_rr
  import axisp_arb_pkg::*;
#(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned DATA_BITS = 512,
  parameter int unsigned ID_BITS   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [N_SRC-1:0][DATA_BITS-1:0]     s_axis_tdata,
  input  logic [N_SRC-1:0][DATA_BITS/8-1:0]   s_axis_tkeep,
  input  logic [N_SRC-1:0]                    s_axis_tlast,
  input  logic [N_SRC-1:0]                    s_axis_tvalid,
  output logic [N_SRC-1:0]                    s_axis_tready,
  output logic [DATA_BITS-1:0]                m_axis_tdata,
  output logic [DATA_BITS/8-1:0]              m_axis_tkeep,
  output logic                                m_axis_tlast,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [ID_BITS-1:0]                  m_id,
  output logic                                busy
`ifdef AXISP_ARB_STATS_EN
  ,
  output logic [N_SRC-1:0][31:0]              stat_pckt_cnt,
  output logic [31:0]                         stat_stall_cnt
`endif
);

  localparam logic [ID_BITS-1:0] PTR_RST = ID_BITS'(N_SRC - 1);

  arb_state_t         state_q, state_d;
  logic [ID_BITS-1:0] grant_q, grant_d;
  logic [ID_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_BITS-1:0] pick_win;
  logic               pick_any;
  logic               beat_last;

  axisp_rr_pick #(
    .N_SRC    (N_SRC),
    .IDX_BITS (ID_BITS)
  ) u_pick (
    .valid_i     (s_axis_tvalid),
    .rr_ptr_i    (rr_ptr_q),
    .winner_o    (pick_win),
    .any_valid_o (pick_any)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= PTR_RST;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Datapath is a pure mux on the registered grant; tvalid is gated so IDLE never moves a beat.
  always_comb begin
    busy                   = (state_q == BUSY);
    m_id                   = grant_q;
    m_axis_tdata           = s_axis_tdata[grant_q];
    m_axis_tkeep           = s_axis_tkeep[grant_q];
    m_axis_tlast           = s_axis_tlast[grant_q];
    m_axis_tvalid          = busy & s_axis_tvalid[grant_q];
    s_axis_tready          = '0;
    if (busy) s_axis_tready[grant_q] = m_axis_tready;
    beat_last              = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_win;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (beat_last) begin
          rr_ptr_d = grant_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef AXISP_ARB_STATS_EN
  logic [N_SRC-1:0][31:0] pckt_cnt_q;
  logic [31:0]            stall_cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pckt_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (beat_last) pckt_cnt_q[grant_q] <= pckt_cnt_q[grant_q] + 32'd1;
      if (m_axis_tvalid && !m_axis_tready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_pckt_cnt  = pckt_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule
